regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default constants for the register file
package regfile_pkg;

  // Controller states: CLEAR zeroes the array after reset, RUN is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_BYPASS = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write (busy) bits
//
// Purpose: tracks which registers have an issued instruction whose result has
// not yet been written back, and reports the busy bit for each read port.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset, clears every busy bit
//   i_run        array is initialised; issues and writes take effect only when 1
//   i_wr_en      write-back strobe, clears busy[i_wr_addr]
//   i_wr_addr    write-back address
//   i_iss_valid  issue strobe, sets busy[i_iss_addr]
//   i_iss_addr   issued destination address
//   i_rd_addr    NUM_RD packed read addresses
//   o_busy       NUM_RD busy bits, one per read port
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_run,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic                     i_iss_valid,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '1;

  logic [DEPTH-1:0] r_busy;

  // The set follows the clear so that an issue and a write-back to the same
  // register in one cycle leave it busy. The zero register is never marked.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else if (i_run) begin
      if (i_wr_en && (i_wr_addr != ZERO_ADDR)) r_busy[i_wr_addr] <= 1'b0;
      if (i_iss_valid && (i_iss_addr != ZERO_ADDR)) r_busy[i_iss_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign o_busy[i] = r_busy[i_rd_addr[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read register file with write bypass and busy scoreboard
//
// Purpose: DEPTH x DATA_W register array, zeroed by a sweep after reset, with
// combinational reads, optional same-cycle write forwarding and a busy bit per
// register. The top address is a hard-wired zero register.
// Ports:
//   clock      clock, rising edge
//   reset_n    synchronous active-low reset, restarts the clearing sweep
//   rd_addr    NUM_RD packed read addresses
//   rd_data    NUM_RD packed read data
//   rd_busy    NUM_RD busy flags for the addressed registers
//   wr_en      write strobe
//   wr_addr    write address
//   wr_data    write data
//   iss_valid  issue strobe, marks iss_addr as pending
//   iss_addr   issued destination address
//   ready      sweep finished; writes and issues are accepted
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int BYPASS = DEF_BYPASS
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '1;
  localparam bit BYP_EN = (BYPASS != 0);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [NUM_RD-1:0] w_sb_busy;

  assign ready = (r_state == RUN);

  // State register and sweep index. The index holds at DEPTH-1 so it cannot
  // start a second pass; RUN is left only through reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == CLEAR) && (r_clr_idx != ZERO_ADDR)) begin
        r_clr_idx <= r_clr_idx + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_idx == ZERO_ADDR) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Data array has no reset of its own; the sweep is what zeroes it.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (r_state == CLEAR) begin
        r_regs[r_clr_idx] <= '0;
      end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
        r_regs[wr_addr] <= wr_data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_run       (ready),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_iss_valid (iss_valid),
    .i_iss_addr  (iss_addr),
    .i_rd_addr   (rd_addr),
    .o_busy      (w_sb_busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_fwd;
    logic              w_iss_hit;

    assign w_ra      = rd_addr[i*ADDR_W +: ADDR_W];
    assign w_zero    = (w_ra == ZERO_ADDR);
    assign w_fwd     = BYP_EN && ready && wr_en && (wr_addr == w_ra) && !w_zero;
    assign w_iss_hit = iss_valid && (iss_addr == w_ra);

    assign rd_data[i*DATA_W +: DATA_W] = (!ready || w_zero) ? '0 :
                                         w_fwd ? wr_data : r_regs[w_ra];
    // A forwarded write retires the pending result, so the register looks
    // free unless a new issue to it lands in the same cycle.
    assign rd_busy[i] = !ready ? 1'b0 : (w_fwd ? w_iss_hit : w_sb_busy[i]);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb, bypass and non-bypass builds
module tb_regfile_sb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  ra0, ra1;
  logic [15:0] rd_addr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_valid;
  logic [7:0]  iss_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        ready_b, ready_n;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  assign rd_addr = {ra1, ra0};

  always #5 clock = ~clock;

  regfile_sb #(.DATA_W(32), .ADDR_W(8), .NUM_RD(2), .BYPASS(1)) u_dut_byp (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_b),
    .rd_busy   (rd_busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .ready     (ready_b)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(8), .NUM_RD(2), .BYPASS(0)) u_dut_nob (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_n),
    .rd_busy   (rd_busy_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .ready     (ready_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%h want=%h", tag, got, want);
    else n_pass++;
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return rd_data_b[31:0];
      1: return rd_data_b[63:32];
      2: return rd_data_n[31:0];
      3: return rd_data_n[63:32];
      4: return {31'b0, rd_busy_b[0]};
      5: return {31'b0, rd_busy_b[1]};
      6: return {31'b0, rd_busy_n[0]};
      7: return {31'b0, rd_busy_n[1]};
      8: return {31'b0, ready_b};
      default: return {31'b0, ready_n};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic exp_data(input string tag, input int port, input logic [31:0] vb, input logic [31:0] vn);
    push({tag, "_byp"}, port, vb);
    push({tag, "_nob"}, 2 + port, vn);
  endtask

  task automatic exp_busy(input string tag, input int port, input logic vb, input logic vn);
    push({tag, "_byp"}, 4 + port, {31'b0, vb});
    push({tag, "_nob"}, 6 + port, {31'b0, vn});
  endtask

  task automatic exp_ready(input string tag, input logic v);
    push({tag, "_byp"}, 8, {31'b0, v});
    push({tag, "_nob"}, 9, {31'b0, v});
  endtask

  // Outputs settle well before the falling edge; compare everything queued.
  task automatic sample();
    exp_t e;
    @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    ra0       = 8'd17;
    ra1       = 8'd0;
    wr_en     = 1'b0;
    wr_addr   = 8'd0;
    wr_data   = 32'd0;
    iss_valid = 1'b0;
    iss_addr  = 8'd0;

    // Reset, then the sweep: ready must rise after exactly 256 edges.
    tick();
    tick();
    reset_n = 1'b1;
    exp_ready("rst_ready", 1'b0);
    exp_busy("rst_busy", 0, 1'b0, 1'b0);
    sample();
    for (int c = 1; c <= 256; c++) begin
      tick();
      exp_ready($sformatf("sweep_ready_c%0d", c), c == 256);
      if (c < 256) exp_data("sweep_data", 0, 32'd0, 32'd0);
      sample();
    end

    tick();
    ra0 = 8'd0;
    ra1 = 8'd17;
    exp_data("idle_r0", 0, 32'd0, 32'd0);
    exp_data("idle_r17", 1, 32'd0, 32'd0);
    sample();
    tick();
    ra0 = 8'd254;
    exp_data("idle_r254", 0, 32'd0, 32'd0);
    exp_busy("idle_busy254", 0, 1'b0, 1'b0);
    sample();

    // Write 0xDEADBEEF to reg 5, both ports reading it.
    tick();
    ra0 = 8'd5;
    ra1 = 8'd5;
    wr_en = 1'b1;
    wr_addr = 8'd5;
    wr_data = 32'hDEADBEEF;
    exp_data("wr5_same_p0", 0, 32'hDEADBEEF, 32'd0);
    exp_data("wr5_same_p1", 1, 32'hDEADBEEF, 32'd0);
    sample();
    tick();
    idle_inputs();
    exp_data("wr5_next_p0", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_data("wr5_next_p1", 1, 32'hDEADBEEF, 32'hDEADBEEF);
    sample();

    // Issue to reg 9, write-back a few cycles later.
    tick();
    ra0 = 8'd9;
    ra1 = 8'd9;
    iss_valid = 1'b1;
    iss_addr = 8'd9;
    exp_busy("iss9_c0", 0, 1'b0, 1'b0);
    sample();
    tick();
    idle_inputs();
    exp_busy("iss9_c1", 0, 1'b1, 1'b1);
    exp_busy("iss9_c1_p1", 1, 1'b1, 1'b1);
    sample();
    tick();
    exp_busy("iss9_c2", 0, 1'b1, 1'b1);
    sample();
    tick();
    wr_en = 1'b1;
    wr_addr = 8'd9;
    wr_data = 32'h0000_0099;
    exp_busy("iss9_wrcyc", 0, 1'b0, 1'b1);
    exp_data("iss9_wrdata", 0, 32'h0000_0099, 32'd0);
    sample();
    tick();
    idle_inputs();
    exp_busy("iss9_after", 0, 1'b0, 1'b0);
    exp_data("iss9_after_data", 0, 32'h0000_0099, 32'h0000_0099);
    sample();

    // Simultaneous issue and write to reg 3: issue wins.
    tick();
    ra0 = 8'd3;
    ra1 = 8'd3;
    wr_en = 1'b1;
    wr_addr = 8'd3;
    wr_data = 32'h3333_0003;
    iss_valid = 1'b1;
    iss_addr = 8'd3;
    exp_busy("both3_same", 0, 1'b1, 1'b0);
    exp_data("both3_same_data", 0, 32'h3333_0003, 32'd0);
    sample();
    tick();
    idle_inputs();
    exp_busy("both3_after", 0, 1'b1, 1'b1);
    exp_busy("both3_after_p1", 1, 1'b1, 1'b1);
    exp_data("both3_after_data", 0, 32'h3333_0003, 32'h3333_0003);
    sample();

    // Zero register ignores writes and issues.
    tick();
    ra0 = 8'd255;
    ra1 = 8'd255;
    wr_en = 1'b1;
    wr_addr = 8'd255;
    wr_data = 32'h0000_1234;
    iss_valid = 1'b1;
    iss_addr = 8'd255;
    exp_data("zr_same", 0, 32'd0, 32'd0);
    exp_busy("zr_same_busy", 1, 1'b0, 1'b0);
    sample();
    tick();
    idle_inputs();
    exp_data("zr_after", 1, 32'd0, 32'd0);
    exp_busy("zr_after_busy", 0, 1'b0, 1'b0);
    sample();

    // Reg 7 = 0xAA, then a one-cycle reset with writes attempted during the sweep.
    tick();
    ra0 = 8'd7;
    ra1 = 8'd3;
    wr_en = 1'b1;
    wr_addr = 8'd7;
    wr_data = 32'h0000_00AA;
    sample();
    tick();
    idle_inputs();
    exp_data("r7_pre", 0, 32'h0000_00AA, 32'h0000_00AA);
    exp_ready("r7_pre_ready", 1'b1);
    sample();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wr_en = 1'b1;
    wr_addr = 8'd7;
    wr_data = 32'h0000_BEEF;
    iss_valid = 1'b1;
    iss_addr = 8'd7;
    exp_ready("rst2_ready", 1'b0);
    exp_data("rst2_r7", 0, 32'd0, 32'd0);
    exp_busy("rst2_busy3", 1, 1'b0, 1'b0);
    sample();
    for (int c = 1; c <= 256; c++) begin
      tick();
      if (c == 256) idle_inputs();
      exp_ready($sformatf("sweep2_ready_c%0d", c), c == 256);
      if (c % 32 == 0) begin
        exp_data($sformatf("sweep2_r7_c%0d", c), 0, 32'd0, 32'd0);
        exp_busy($sformatf("sweep2_busy7_c%0d", c), 0, 1'b0, 1'b0);
      end
      sample();
    end
    tick();
    ra1 = 8'd5;
    exp_data("post_r7", 0, 32'd0, 32'd0);
    exp_data("post_r5", 1, 32'd0, 32'd0);
    exp_busy("post_busy7", 0, 1'b0, 1'b0);
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
